// File: rtl/cpu_pkg.sv
// Shared types and constants for the integer pipeline.
package cpu_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO  = 5'd0;
    localparam word_t    BUBBLE_PC = 32'h0000_0001;

endpackage

// File: rtl/regfile_core.sv
// 32x32 architectural register array: one write port, three asynchronous read ports, r0 hardwired to zero.
module regfile_core
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     we,
    input  reg_idx_t wa,
    input  word_t    wd,
    input  reg_idx_t ra_a,
    input  reg_idx_t ra_b,
    input  reg_idx_t ra_c,
    output word_t    rd_a,
    output word_t    rd_b,
    output word_t    rd_c
);

    word_t regs [32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != REG_ZERO)) begin
            regs[wa] <= wd;
        end
    end

    // r0 is masked on read so its storage slot never matters.
    assign rd_a = (ra_a == REG_ZERO) ? '0 : regs[ra_a];
    assign rd_b = (ra_b == REG_ZERO) ? '0 : regs[ra_b];
    assign rd_c = (ra_c == REG_ZERO) ? '0 : regs[ra_c];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it, serves D-stage reads with
// same-cycle write-through, and tracks retirement for debug.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int    RETIRE_W  = 32,
    parameter word_t BUBBLE_PC = cpu_pkg::BUBBLE_PC
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                w_wreg,
    input  logic                w_m2reg,
    input  word_t               w_data,
    input  word_t               w_memout,
    input  reg_idx_t            w_rn,
    input  word_t               dbg_w_pc,
    input  word_t               dbg_w_inst,
    input  reg_idx_t            d_rs,
    input  reg_idx_t            d_rt,
    output word_t               d_qa,
    output word_t               d_qb,
    input  reg_idx_t            dbg_rn,
    output word_t               dbg_q,
    output word_t               wb_value,
    output logic [RETIRE_W-1:0] retire_cnt,
    output word_t               last_pc,
    output word_t               last_inst
);

    word_t core_qa;
    word_t core_qb;
    logic  commit;
    logic  slot_valid;

    assign wb_value   = w_m2reg ? w_memout : w_data;
    assign commit     = w_wreg && (w_rn != REG_ZERO);
    assign slot_valid = (dbg_w_pc != BUBBLE_PC);

    regfile_core u_core (
        .clk    (clk),
        .resetn (resetn),
        .we     (commit),
        .wa     (w_rn),
        .wd     (wb_value),
        .ra_a   (d_rs),
        .ra_b   (d_rt),
        .ra_c   (dbg_rn),
        .rd_a   (core_qa),
        .rd_b   (core_qb),
        .rd_c   (dbg_q)
    );

    // Write-through so a D-stage read sees the W-stage commit of the same cycle.
    assign d_qa = (commit && (w_rn == d_rs)) ? wb_value : core_qa;
    assign d_qb = (commit && (w_rn == d_rt)) ? wb_value : core_qb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_cnt <= '0;
            last_pc    <= BUBBLE_PC;
            last_inst  <= '0;
        end else if (slot_valid) begin
            retire_cnt <= retire_cnt + 1'b1;
            last_pc    <= dbg_w_pc;
            last_inst  <= dbg_w_inst;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, wrap and async-reset sequences.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        w_wreg, w_m2reg;
    logic [31:0] w_data, w_memout, dbg_w_pc, dbg_w_inst;
    logic [4:0]  w_rn, d_rs, d_rt, dbg_rn;
    logic [31:0] d_qa, d_qb, dbg_q, wb_value, retire_cnt, last_pc, last_inst;
    logic [31:0] d_qa4, d_qb4, dbg_q4, wb_value4, last_pc4, last_inst4;
    logic [3:0]  retire_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .resetn(resetn), .w_wreg(w_wreg), .w_m2reg(w_m2reg),
        .w_data(w_data), .w_memout(w_memout), .w_rn(w_rn),
        .dbg_w_pc(dbg_w_pc), .dbg_w_inst(dbg_w_inst), .d_rs(d_rs), .d_rt(d_rt),
        .d_qa(d_qa), .d_qb(d_qb), .dbg_rn(dbg_rn), .dbg_q(dbg_q),
        .wb_value(wb_value), .retire_cnt(retire_cnt), .last_pc(last_pc),
        .last_inst(last_inst)
    );

    wb_regfile #(.RETIRE_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .w_wreg(w_wreg), .w_m2reg(w_m2reg),
        .w_data(w_data), .w_memout(w_memout), .w_rn(w_rn),
        .dbg_w_pc(dbg_w_pc), .dbg_w_inst(dbg_w_inst), .d_rs(d_rs), .d_rt(d_rt),
        .d_qa(d_qa4), .d_qb(d_qb4), .dbg_rn(dbg_rn), .dbg_q(dbg_q4),
        .wb_value(wb_value4), .retire_cnt(retire_cnt4), .last_pc(last_pc4),
        .last_inst(last_inst4)
    );

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic [31:0] data;
        logic [31:0] memout;
        logic [4:0]  rn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  drn;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] wbv;
        logic [31:0] dbg_pre;
        logic [31:0] dbg_post;
        logic [31:0] cnt;
        logic [31:0] lpc;
        logic [31:0] linst;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_wreg = 0; w_m2reg = 0; w_data = '0; w_memout = '0; w_rn = '0;
        d_rs = '0; d_rt = '0; dbg_rn = '0; dbg_w_pc = 32'h1; dbg_w_inst = '0;
    endtask

    initial begin
        //          wreg m2 data          memout        rn     rs     rt     drn    pc             inst           qa            qb            wbv           dbg_pre       dbg_post      cnt lpc            linst
        vecs[0] = '{1, 0, 32'hDEADBEEF, 32'h00000000, 5'd5,  5'd5,  5'd0,  5'd5,  32'h00000001, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 0, 32'h00000001, 32'h00000000};
        vecs[1] = '{1, 1, 32'hFFFFFFFF, 32'h12345678, 5'd7,  5'd7,  5'd7,  5'd5,  32'h00000001, 32'h00000000, 32'h12345678, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h00000001, 32'h00000000};
        vecs[2] = '{1, 0, 32'h00000001, 32'h00000000, 5'd0,  5'd0,  5'd5,  5'd0,  32'h00400000, 32'hAAAA0001, 32'h00000000, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 32'h00000000, 1, 32'h00400000, 32'hAAAA0001};
        vecs[3] = '{0, 0, 32'h55555555, 32'h00000000, 5'd5,  5'd5,  5'd7,  5'd7,  32'h00000001, 32'hBBBB0002, 32'hDEADBEEF, 32'h12345678, 32'h55555555, 32'h12345678, 32'h12345678, 1, 32'h00400000, 32'hAAAA0001};
        vecs[4] = '{1, 0, 32'h0A0A0A0A, 32'h00000000, 5'd5,  5'd7,  5'd5,  5'd5,  32'h00400004, 32'hCCCC0003, 32'h12345678, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'hDEADBEEF, 32'h0A0A0A0A, 2, 32'h00400004, 32'hCCCC0003};
        vecs[5] = '{1, 1, 32'h00000000, 32'h000000FF, 5'd31, 5'd31, 5'd30, 5'd31, 32'h00000001, 32'hDDDD0004, 32'h000000FF, 32'h00000000, 32'h000000FF, 32'h00000000, 32'h000000FF, 2, 32'h00400004, 32'hCCCC0003};
        vecs[6] = '{0, 0, 32'h00000000, 32'h00000000, 5'd0,  5'd31, 5'd5,  5'd0,  32'h00000001, 32'h00000000, 32'h000000FF, 32'h0A0A0A0A, 32'h00000000, 32'h00000000, 32'h00000000, 2, 32'h00400004, 32'hCCCC0003};

        resetn = 0;
        idle();
        tick();
        tick();
        @(negedge clk);
        resetn = 1;
        #1;

        for (int i = 0; i < 32; i++) begin
            dbg_rn = i[4:0];
            #1;
            chk($sformatf("reset_dbg_q[%0d]", i), dbg_q, 32'h0);
        end
        chk("reset_retire_cnt", retire_cnt, 32'h0);
        chk("reset_last_pc", last_pc, 32'h1);
        chk("reset_last_inst", last_inst, 32'h0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            w_wreg = vecs[i].wreg; w_m2reg = vecs[i].m2reg;
            w_data = vecs[i].data; w_memout = vecs[i].memout; w_rn = vecs[i].rn;
            d_rs = vecs[i].rs; d_rt = vecs[i].rt; dbg_rn = vecs[i].drn;
            dbg_w_pc = vecs[i].pc; dbg_w_inst = vecs[i].inst;
            #1;
            chk($sformatf("v%0d_d_qa", i), d_qa, vecs[i].qa);
            chk($sformatf("v%0d_d_qb", i), d_qb, vecs[i].qb);
            chk($sformatf("v%0d_wb_value", i), wb_value, vecs[i].wbv);
            chk($sformatf("v%0d_dbg_q_pre", i), dbg_q, vecs[i].dbg_pre);
            tick();
            chk($sformatf("v%0d_dbg_q_post", i), dbg_q, vecs[i].dbg_post);
            chk($sformatf("v%0d_retire_cnt", i), retire_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_last_pc", i), last_pc, vecs[i].lpc);
            chk($sformatf("v%0d_last_inst", i), last_inst, vecs[i].linst);
        end
        chk("narrow_cnt_after_table", {28'h0, retire_cnt4}, 32'h2);

        // Counter wrap on the 4-bit instance; 32-bit instance keeps counting.
        @(negedge clk);
        idle();
        resetn = 0;
        #1;
        resetn = 1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            dbg_w_pc = 32'h1000 + 32'(i * 4);
            dbg_w_inst = 32'hE000_0000 + 32'(i);
            tick();
            if (i == 14) chk("wrap_cnt4_at_15", {28'h0, retire_cnt4}, 32'd15);
            if (i == 15) chk("wrap_cnt4_to_0", {28'h0, retire_cnt4}, 32'd0);
        end
        chk("wrap_cnt4_17", {28'h0, retire_cnt4}, 32'd1);
        chk("wrap_cnt32_17", retire_cnt, 32'd17);
        chk("wrap_last_pc", last_pc, 32'h1040);
        chk("wrap_last_inst", last_inst, 32'hE000_0010);

        // Async reset mid-cycle after a commit.
        @(negedge clk);
        idle();
        w_wreg = 1; w_rn = 5'd9; w_data = 32'h0001_2345; dbg_w_pc = 32'h2000; dbg_w_inst = 32'hF00D;
        tick();
        w_wreg = 0; dbg_w_pc = 32'h1; dbg_rn = 5'd9;
        #1;
        chk("pre_reset_dbg_q9", dbg_q, 32'h0001_2345);
        #1;
        resetn = 0;
        #1;
        chk("async_dbg_q9", dbg_q, 32'h0);
        chk("async_retire_cnt", retire_cnt, 32'h0);
        chk("async_last_pc", last_pc, 32'h1);
        chk("async_last_inst", last_inst, 32'h0);
        // Edge under reset: commit and retirement suppressed, bypass still live.
        w_wreg = 1; w_rn = 5'd9; w_data = 32'hCAFE_F00D; d_rs = 5'd9; d_rt = 5'd9;
        dbg_w_pc = 32'h3000; dbg_w_inst = 32'h1234;
        #1;
        chk("reset_bypass_qa", d_qa, 32'hCAFE_F00D);
        chk("reset_bypass_qb", d_qb, 32'hCAFE_F00D);
        tick();
        chk("reset_edge_dbg_q9", dbg_q, 32'h0);
        chk("reset_edge_cnt", retire_cnt, 32'h0);
        chk("reset_edge_last_pc", last_pc, 32'h1);
        @(negedge clk);
        idle();
        resetn = 1;
        #1;
        chk("post_reset_qa", d_qa, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
